// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the PC and instruction-memory handshake,
// holds one fetched word for decode and counts retired handshakes.
module fetch_sequencer #(
  parameter int m    = 32,
  parameter int STEP = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [m-1:0] pc_cur,
  output logic [m-1:0] pc_next,
  output logic         imem_req,
  output logic [m-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic         instr_valid,
  output logic [31:0]  instr,
  input  logic         instr_ready,
  input  logic         redirect,
  input  logic [m-1:0] redirect_target,
  output logic [31:0]  retired_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] VALID = 2'd3;

  localparam logic [m-1:0] STEP_W = m'(STEP);

  logic [1:0]   state_r;
  logic [1:0]   state_nxt_s;
  logic [m-1:0] tgt_r;
  logic [m-1:0] tgt_nxt_s;
  logic [31:0]  instr_r;
  logic [31:0]  cnt_r;
  logic [m-1:0] pc_nxt_s;
  logic         load_instr_s;
  logic         retire_s;

  // Next-state, next-PC and side-effect decode for the fetch loop
  always_comb begin
    state_nxt_s  = state_r;
    tgt_nxt_s    = tgt_r;
    pc_nxt_s     = pc_cur;
    load_instr_s = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (imem_ack && !redirect) begin
          load_instr_s = 1'b1;
          pc_nxt_s     = pc_cur + STEP_W;
          state_nxt_s  = VALID;
        end else if (imem_ack && redirect) begin
          pc_nxt_s    = redirect_target;
          state_nxt_s = REQ;
        end else if (redirect) begin
          // Address must stay put until the in-flight request completes
          tgt_nxt_s   = redirect_target;
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = REQ;
        end
      end
      FLUSH: begin
        if (imem_ack) begin
          pc_nxt_s    = redirect ? redirect_target : tgt_r;
          state_nxt_s = REQ;
        end else if (redirect) begin
          tgt_nxt_s   = redirect_target;
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      VALID: begin
        retire_s = instr_ready;
        if (redirect) begin
          pc_nxt_s    = redirect_target;
          state_nxt_s = REQ;
        end else if (instr_ready) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = VALID;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, stored redirect target, instruction word and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      tgt_r   <= {m{1'b0}};
      instr_r <= 32'd0;
      cnt_r   <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      tgt_r   <= tgt_nxt_s;
      if (load_instr_s) begin
        instr_r <= imem_rdata;
      end
      if (retire_s) begin
        cnt_r <= cnt_r + 32'd1;
      end
    end
  end

  // Reset gates the decoded outputs so they are quiet during the reset cycle itself
  assign pc_next     = reset ? {m{1'b0}} : pc_nxt_s;
  assign imem_req    = !reset && ((state_r == REQ) || (state_r == FLUSH));
  assign imem_addr   = pc_cur;
  assign instr_valid = !reset && (state_r == VALID);
  assign instr       = instr_r;
  assign retired_cnt = cnt_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against a transaction-level
// model of the fetch loop, plus directed boundary scenarios.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc_cur = 32'd0;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] retired_cnt;

  int checks = 0;
  int errors = 0;

  // Model: loop entered, instruction held for decode, redirect awaiting old ack
  bit          m_run, m_has, m_disc;
  logic [31:0] m_tgt, m_instr, m_cnt, m_pc;

  fetch_sequencer #(.m(32), .STEP(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_cur(pc_cur), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .redirect(redirect),
    .redirect_target(redirect_target), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // External PC register fed by the sequencer
  always @(posedge clk) pc_cur <= pc_next;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_cycle(input logic rs, input logic st, input logic ak,
                             input logic [31:0] rdat, input logic rdy,
                             input logic rd, input logic [31:0] tg);
    logic        exp_req;
    logic [31:0] exp_pc;
    @(negedge clk);
    reset = rs; start = st; imem_ack = ak; imem_rdata = rdat;
    instr_ready = rdy; redirect = rd; redirect_target = tg;
    #1;
    exp_req = !rs && m_run && !m_has;
    if (rs)            exp_pc = 32'd0;
    else if (!m_run)   exp_pc = m_pc;
    else if (m_has)    exp_pc = rd ? tg : m_pc;
    else if (!ak)      exp_pc = m_pc;
    else if (rd)       exp_pc = tg;
    else if (m_disc)   exp_pc = m_tgt;
    else               exp_pc = m_pc + 32'd4;
    check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    check("instr_valid", {31'd0, instr_valid}, {31'd0, !rs && m_has});
    check("pc_next", pc_next, exp_pc);
    check("instr", instr, m_instr);
    check("retired_cnt", retired_cnt, m_cnt);
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    // Advance the model to the state after this edge
    if (rs) begin
      m_run = 0; m_has = 0; m_disc = 0;
      m_tgt = 32'd0; m_instr = 32'd0; m_cnt = 32'd0;
    end else if (!m_run) begin
      m_run = st;
    end else if (m_has) begin
      if (rdy) m_cnt = m_cnt + 32'd1;
      if (rdy || rd) m_has = 0;
    end else if (m_disc) begin
      if (ak) m_disc = 0;
      else if (rd) m_tgt = tg;
    end else if (ak && !rd) begin
      m_instr = rdat; m_has = 1;
    end else if (!ak && rd) begin
      m_disc = 1; m_tgt = tg;
    end
    m_pc = exp_pc;
  endtask

  initial begin
    logic [31:0] addrs[$];
    logic [31:0] tg;
    m_run = 0; m_has = 0; m_disc = 0;
    m_tgt = 32'd0; m_instr = 32'd0; m_cnt = 32'd0; m_pc = 32'd0;
    repeat (2) @(posedge clk);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check("reset_cnt", retired_cnt, 32'd0);

    // Back-to-back fetch with immediate ack and ready
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 32'h1000_0000 + 32'(i), 1'b1, 1'b0, 32'd0);
      if (imem_req) addrs.push_back(imem_addr);
    end
    check("seq_len", 32'(addrs.size()), 32'd4);
    for (int i = 0; i < 4 && i < addrs.size(); i++) check("seq_addr", addrs[i], 32'(4 * i));
    check("seq_retired", retired_cnt, 32'd3);

    // PC wrap: redirect to the top word, then fetch it
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    drive_cycle(1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 32'd0);
    check("wrap_pc", pc_next, 32'd0);

    // Decode stall holds the instruction
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      check("stall_instr", instr, 32'hCAFE_0001);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

    // Redirect to 0x10 on ack, then delayed ack
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b1, 32'h10);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      check("wait_addr", imem_addr, 32'h10);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
    check("ack_pc", pc_next, 32'h14);

    // Redirect with request outstanding: fetched word must be dropped
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h100);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check("flush_addr", imem_addr, 32'h100);
    check("flush_valid", {31'd0, instr_valid}, 32'd0);

    // Reset while flushing, then a stray ack
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h200);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_0000, 1'b0, 1'b0, 32'd0);
    check("rst_pc", pc_next, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_cnt", retired_cnt, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tg = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      drive_cycle($urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0,
                  1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 15, tg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter m, default 32: address/PC width in bits.
REQ-002 Parameter STEP, default 4: byte increment between sequential instructions.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 start  input  1  level; while high in IDLE, begin fetching.
REQ-006 pc_cur  input  m  current PC register value.
REQ-007 pc_next  output  m  next PC value; the PC register loads it every cycle.
REQ-008 imem_req  output  1  instruction-memory request, held until imem_ack.
REQ-009 imem_addr  output  m  request address; equals pc_cur whenever imem_req=1.
REQ-010 imem_ack  input  1  memory completes the request this cycle; imem_rdata valid.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 instr_valid  output  1  instr holds a fetched instruction for decode.
REQ-013 instr  output  32  registered instruction word.
REQ-014 instr_ready  input  1  decode accepts instr this cycle.
REQ-015 redirect  input  1  single-cycle pulse: branch/jump taken.
REQ-016 redirect_target  input  m  new PC, valid with redirect.
REQ-017 retired_cnt  output  32  count of instr_valid&instr_ready handshakes.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, FLUSH and VALID.
REQ-019 Default: pc_next = pc_cur (hold) unless a rule below specifies otherwise.
REQ-020 IDLE: imem_req=0, instr_valid=0; start=1 -> REQ next cycle; imem_ack ignored.
REQ-021 REQ: imem_req=1, imem_addr=pc_cur; no ack and no redirect -> stay in REQ.
REQ-022 REQ, ack=1, redirect=0: instr <= imem_rdata, pc_next = pc_cur+STEP, -> VALID.
REQ-023 REQ, ack=1, redirect=1: fetched word discarded, pc_next = redirect_target, -> REQ.
REQ-024 REQ, ack=0, redirect=1: redirect_target stored in an internal register, pc_next = pc_cur (address held stable), -> FLUSH.
REQ-025 FLUSH: imem_req=1 at the old address; a further redirect overwrites the stored target (last one wins).
REQ-026 FLUSH, ack=1: data discarded, pc_next = stored target (or redirect_target if redirect=1 this same cycle), -> REQ.
REQ-027 VALID: instr_valid=1, instr stable, imem_req=0; instr_ready=1 -> REQ, retired_cnt+1.
REQ-028 VALID, redirect=1: pc_next = redirect_target, -> REQ; instr_valid drops next cycle.
REQ-029 VALID, redirect=1 with instr_ready=1: handshake counts (retired_cnt+1), redirect sets the PC.
REQ-030 pc_cur+STEP SHALL wrap modulo 2^m (0xFFFFFFFC+4 -> 0x00000000 at m=32).
REQ-031 retired_cnt SHALL wrap modulo 2^32 without saturating.
REQ-032 start is sampled only in IDLE; the fetch loop, once entered, runs until reset.
REQ-033 Steady-state latency: request-to-instr_valid is 1 cycle after ack; with ack and ready both immediate, throughput is one instruction per 2 cycles.

Reset
REQ-034 While reset=1: state -> IDLE, imem_req=0, instr_valid=0, instr=0, retired_cnt=0, stored target=0, pc_next=0.
REQ-035 Reset mid-transaction SHALL abandon the outstanding request; an imem_ack arriving after reset is ignored in IDLE.
REQ-036 Reset has priority over every other input in the same cycle.

Verification
REQ-037 Reset, start=1, ack and ready always 1 -> imem_addr sequence 0,4,8,12; retired_cnt=3 after third accept.
REQ-038 PC=0x10 in REQ, ack delayed 3 cycles -> imem_req high and imem_addr=0x10 for 4 cycles; pc_next stays 0x10 until ack.
REQ-039 Redirect to 0x100 during REQ with no ack, ack 2 cycles later with 0xDEADBEEF -> instr_valid stays 0, next imem_addr=0x100.
REQ-040 VALID with instr_ready=0 for 5 cycles -> instr_valid and instr stable, imem_req=0, retired_cnt unchanged.
REQ-041 pc_cur=0xFFFFFFFC, ack -> pc_next=0x00000000.
REQ-042 Reset asserted in FLUSH then ack pulse -> state IDLE, instr_valid=0, pc_next=0, retired_cnt=0.
